branch_resolve_queue: RTL
=========================

# branch_resolve_queue

Parametrised branch/jump resolution stage that decouples resolution from issue. Computes condition and target for each issued branch or jump, holds up to DEPTH unresolved entries, links each to the PC of the instruction issued after it, and drains results in order over a valid/ready port to the predictor and fetch. On a misprediction it raises a flush and discards all younger (wrong-path) entries. Sits beside the issue stage and replaces the single-entry branch hold.

## Interface
- XLEN, 32: data/PC width.
- ID_W, 3: instruction id width.
- DEPTH, 4: queue entries; power of two, at least 2.
- C_EXT, 0: 1 = compressed ISA, so the misalignment check is disabled.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  branch/jump issued this cycle.
- req_ready  out  1  space available; equals count < DEPTH.
- req_id  in  ID_W  instruction id.
- req_pc  in  XLEN  PC of the branch.
- req_rs1, req_rs2  in  XLEN  operands.
- req_fn3  in  3  bit2 = less-than, bit1 = unsigned, bit0 = invert.
- req_jal, req_jalr  in  1  jump type; mutually exclusive.
- req_offset  in  21  sign-extended immediate.
- req_fallthrough  in  XLEN  not-taken PC.
- req_is_call, req_is_return  in  1  RAS hints.
- next_valid  in  1  a following instruction reached issue.
- next_pc  in  XLEN  its PC.
- flush_in  in  1  external flush (exception/interrupt).
- res_valid  out  1  head entry resolved.
- res_ready  in  1  consumer accepts.
- res_id, res_pc, res_target  out  ID_W/XLEN/XLEN  result.
- res_taken, res_is_branch, res_is_call, res_is_return  out  1  predictor update fields.
- branch_flush  out  1  mispredict, one-cycle pulse.
- exc_valid  out  1  misaligned-target exception, one-cycle pulse.
- exc_tval  out  XLEN  offending target.

## Operation
- Condition: extend both operands to XLEN+1 bits, using the sign bit when fn3[1] = 0. lt = a < b (signed); eq = a == b. cond = (fn3[2] ? lt : eq) ^ fn3[0].
- Taken: taken = cond | jal | jalr.
- Taken target: (jalr ? rs1 : pc) + sext(offset), with bit0 cleared for jalr.
- target: the taken target when taken, otherwise req_fallthrough. Computed and stored when the request is accepted.
- misaligned: taken & target[1] & (C_EXT == 0).
- Entry states: EMPTY -> WAIT (on accept) -> LINKED (on next_valid, storing next_pc) -> EMPTY (on drain).
- At most one entry is in WAIT: the youngest.
- next_valid links the WAIT entry. If no entry is in WAIT, next_valid is ignored.
- An entry accepted in cycle N is never linked by a next_valid in the same cycle N. That next_valid links the previous WAIT entry, if any.
- res_valid = head entry is LINKED. All res_* fields are driven from the head entry's registers.
- Drain: res_valid & res_ready.
- mispredict = next_pc[XLEN-1:1] != target[XLEN-1:1].
- On a drain of a non-misaligned entry: branch_flush = mispredict.
- On a drain of a misaligned entry: exc_valid = 1, exc_tval = target, branch_flush = 0.
- On drain with branch_flush or exc_valid: every other entry is cleared. A request or next_valid in the same cycle is dropped.
- flush_in has highest priority: all entries are cleared and request/next_valid in that cycle are dropped. A drain in the same cycle still completes and its outputs are valid.
- Full: req_ready = 0. When full, a drain in that cycle does not raise req_ready in that same cycle.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide.

## Timing
- Reset (asynchronous): all entries EMPTY, pointers and count 0, res_valid = 0, req_ready = 1.
- Reset: branch_flush = 0, exc_valid = 0; all data outputs 0.
- Reset asserted mid-operation discards all entries immediately.
- Latency: accept in cycle N, next_valid in cycle N+1 -> res_valid in cycle N+2.
- res_valid holds with stable fields until accepted.
- branch_flush and exc_valid are combinational from the head registers and res_ready. They are valid only in the drain cycle.
- Throughput: one accept, one link and one drain per cycle, simultaneously.

## Test plan
- BEQ, rs1 = rs2 = 5, pc 0x100, offset 0x20, next_pc 0x120 -> res_taken = 1, res_target = 0x120, branch_flush = 0.
- BLTU rs1 = 0xFFFFFFFF, rs2 = 1, fallthrough 0x104, next_pc 0x104 -> not taken, no flush.
- BLT with the same operands, offset 8, pc 0x100, next_pc 0x104 -> taken, target 0x108, branch_flush = 1; two younger queued entries are discarded.
- JALR rs1 = 0x201, offset 0, C_EXT = 0 -> target 0x200 (bit0 cleared), no exception.
- JAL pc 0x100, offset 2, C_EXT = 0 -> target 0x102, exc_valid = 1, exc_tval = 0x102, branch_flush = 0.
- DEPTH = 4, res_ready = 0: five requests -> req_ready = 0 after the fourth. Raising res_ready drains 4 results in id order. flush_in mid-sequence -> queue empty next cycle, req_ready = 1.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// Branch/jump resolution queue: resolves at issue, links the successor PC,
// and drains results in order to the predictor and fetch.
module branch_resolve_queue #(
   parameter int XLEN  = 32,
   parameter int ID_W  = 3,
   parameter int DEPTH = 4,
   parameter int C_EXT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [ID_W-1:0] req_id,
   input  logic [XLEN-1:0] req_pc,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   input  logic [2:0]      req_fn3,
   input  logic            req_jal,
   input  logic            req_jalr,
   input  logic [20:0]     req_offset,
   input  logic [XLEN-1:0] req_fallthrough,
   input  logic            req_is_call,
   input  logic            req_is_return,
   input  logic            next_valid,
   input  logic [XLEN-1:0] next_pc,
   input  logic            flush_in,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [ID_W-1:0] res_id,
   output logic [XLEN-1:0] res_pc,
   output logic [XLEN-1:0] res_target,
   output logic            res_taken,
   output logic            res_is_branch,
   output logic            res_is_call,
   output logic            res_is_return,
   output logic            branch_flush,
   output logic            exc_valid,
   output logic [XLEN-1:0] exc_tval
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {EMPTY, WAIT, LINKED} st_t;

   st_t             st_q   [DEPTH];
   logic [ID_W-1:0] id_q   [DEPTH];
   logic [XLEN-1:0] pc_q   [DEPTH];
   logic [XLEN-1:0] tgt_q  [DEPTH];
   logic [XLEN-1:1] npc_q  [DEPTH];
   logic            tkn_q  [DEPTH];
   logic            br_q   [DEPTH];
   logic            call_q [DEPTH];
   logic            ret_q  [DEPTH];
   logic            mis_q  [DEPTH];

   logic [PW-1:0] head, tail, last;
   logic [PW:0]   count;

   logic [XLEN:0]   op_a, op_b;
   logic            lt, eq, cond, taken, mis;
   logic [XLEN-1:0] base, tt, target;

   logic has_wait, drain, mispred, kill, accept, link;
   logic unused_ok;

   always_comb begin
      op_a   = {~req_fn3[1] & req_rs1[XLEN-1], req_rs1};
      op_b   = {~req_fn3[1] & req_rs2[XLEN-1], req_rs2};
      lt     = $signed(op_a) < $signed(op_b);
      eq     = op_a == op_b;
      cond   = (req_fn3[2] ? lt : eq) ^ req_fn3[0];
      taken  = cond | req_jal | req_jalr;
      base   = req_jalr ? req_rs1 : req_pc;
      tt     = base + {{(XLEN-21){req_offset[20]}}, req_offset};
      if (req_jalr) tt[0] = 1'b0;
      target = taken ? tt : req_fallthrough;
      mis    = taken & target[1] & (C_EXT == 0);
   end

   assign last      = tail - PW'(1);
   assign has_wait  = (count != '0) && (st_q[last] == WAIT);
   assign req_ready = count < (PW+1)'(DEPTH);

   assign res_valid     = st_q[head] == LINKED;
   assign res_id        = id_q[head];
   assign res_pc        = pc_q[head];
   assign res_target    = tgt_q[head];
   assign res_taken     = tkn_q[head];
   assign res_is_branch = br_q[head];
   assign res_is_call   = call_q[head];
   assign res_is_return = ret_q[head];
   assign exc_tval      = tgt_q[head];

   assign drain        = res_valid & res_ready;
   assign mispred      = npc_q[head] != tgt_q[head][XLEN-1:1];
   assign exc_valid    = drain & mis_q[head];
   assign branch_flush = drain & ~mis_q[head] & mispred;

   // Any redirect squashes the wrong-path traffic of this cycle too
   assign kill   = flush_in | branch_flush | exc_valid;
   assign accept = req_valid & req_ready & ~kill;
   assign link   = next_valid & has_wait & ~kill;

   assign unused_ok = next_pc[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            st_q[i]   <= EMPTY;
            id_q[i]   <= '0;
            pc_q[i]   <= '0;
            tgt_q[i]  <= '0;
            npc_q[i]  <= '0;
            tkn_q[i]  <= 1'b0;
            br_q[i]   <= 1'b0;
            call_q[i] <= 1'b0;
            ret_q[i]  <= 1'b0;
            mis_q[i]  <= 1'b0;
         end
      end else if (kill) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) st_q[i] <= EMPTY;
      end else begin
         if (drain) begin
            st_q[head] <= EMPTY;
            head       <= head + PW'(1);
         end
         if (link) begin
            st_q[last]  <= LINKED;
            npc_q[last] <= next_pc[XLEN-1:1];
         end
         if (accept) begin
            st_q[tail]   <= WAIT;
            id_q[tail]   <= req_id;
            pc_q[tail]   <= req_pc;
            tgt_q[tail]  <= target;
            tkn_q[tail]  <= taken;
            br_q[tail]   <= ~(req_jal | req_jalr);
            call_q[tail] <= req_is_call;
            ret_q[tail]  <= req_is_return;
            mis_q[tail]  <= mis;
            tail         <= tail + PW'(1);
         end
         count <= count + (PW+1)'(accept) - (PW+1)'(drain);
      end
   end

endmodule
